uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter_if.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - producer/transmitter bundle for the round-robin UART TX arbiter
//
// Signals:
//   req         producer -> arbiter   per-requester byte request (level)
//   req_data    producer -> arbiter   byte i on bits [8i+7:8i]
//   gnt         arbiter  -> producer  one-hot grant pulse (byte captured)
//   tx_done     arbiter  -> producer  one-hot completion pulse
//   tx_err      arbiter  -> producer  watchdog abort pulse
//   busy        arbiter  -> producer  frame in flight (grant through DONE)
//   owner       arbiter  -> producer  index of current/last owner
//   uart_dintx  arbiter  -> UART      byte to transmit
//   uart_newd   arbiter  -> UART      start request
//   uart_donetx UART     -> arbiter   transmitter done flag
// Modports: master = producer/transmitter side, slave = arbiter.

interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]         req;
    logic [8*NUM_REQ-1:0]       req_data;
    logic [NUM_REQ-1:0]         gnt;
    logic [NUM_REQ-1:0]         tx_done;
    logic                       tx_err;
    logic                       busy;
    logic [$clog2(NUM_REQ)-1:0] owner;
    logic [7:0]                 uart_dintx;
    logic                       uart_newd;
    logic                       uart_donetx;

    modport master (
        output req, req_data, uart_donetx,
        input  gnt, tx_done, tx_err, busy, owner, uart_dintx, uart_newd
    );

    modport slave (
        input  req, req_data, uart_donetx,
        output gnt, tx_done, tx_err, busy, owner, uart_dintx, uart_newd
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among NUM_REQ producers
//
// Ports:
//   clk  system clock, posedge
//   rst  asynchronous active-low reset
//   bus  uart_tx_arbiter_if.slave (req/req_data in, gnt/tx_done/tx_err/busy/owner out,
//        uart_dintx/uart_newd out, uart_donetx in)
// Parameters:
//   NUM_REQ         number of requesters (2..16)
//   TIMEOUT_CYCLES  SEND watchdog limit, only used when UART_ARB_TIMEOUT_EN is defined
// Optional feature: define UART_ARB_TIMEOUT_EN to enable the SEND-state watchdog;
// without it tx_err stays 0 and SEND waits for donetx indefinitely.

module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    state_t               state;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        owner_r;
    logic [NUM_REQ-1:0]   gnt_r;
    logic [NUM_REQ-1:0]   done_r;
    logic                 err_r;
    logic                 busy_r;
    logic                 newd_r;
    logic [7:0]           dintx_r;
    logic                 donetx_q;

    logic                 win_found;
    logic [IW-1:0]        win_idx;
    logic [7:0]           win_byte;
    logic                 donetx_rise;
    logic                 timeout_hit;

    // A level-high donetx at SEND entry must not complete the frame, so only
    // a 0->1 transition counts.
    assign donetx_rise = bus.uart_donetx & ~donetx_q;

    // Round-robin search: first pass covers indices at or above ptr, second
    // pass wraps to the indices below it. Loop indices stay constant so the
    // byte select is a plain mux.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_byte  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && bus.req[i] && (IW'(i) >= ptr)) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
                win_byte  = bus.req_data[i*8 +: 8];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && bus.req[i] && (IW'(i) < ptr)) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
                win_byte  = bus.req_data[i*8 +: 8];
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [31:0] wd_cnt;

    // Cleared while idle so it starts from zero on SEND entry; the abort fires
    // on the TIMEOUT_CYCLES-th SEND edge after the grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (state == S_IDLE) begin
            wd_cnt <= '0;
        end else if (state == S_SEND) begin
            wd_cnt <= wd_cnt + 32'd1;
        end
    end

    assign timeout_hit = (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            owner_r  <= '0;
            gnt_r    <= '0;
            done_r   <= '0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
            newd_r   <= 1'b0;
            dintx_r  <= 8'h00;
            donetx_q <= 1'b0;
        end else begin
            donetx_q <= bus.uart_donetx;
            gnt_r    <= '0;
            done_r   <= '0;
            err_r    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        owner_r <= win_idx;
                        dintx_r <= win_byte;
                        newd_r  <= 1'b1;
                        busy_r  <= 1'b1;
                        gnt_r   <= NUM_REQ'(1) << win_idx;
                        ptr     <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
                        state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (donetx_rise) begin
                        newd_r <= 1'b0;
                        done_r <= NUM_REQ'(1) << owner_r;
                        state  <= S_DONE;
                    end else if (timeout_hit) begin
                        newd_r <= 1'b0;
                        err_r  <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt        = gnt_r;
    assign bus.tx_done    = done_r;
    assign bus.tx_err     = err_r;
    assign bus.busy       = busy_r;
    assign bus.owner      = owner_r;
    assign bus.uart_dintx = dintx_r;
    assign bus.uart_newd  = newd_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a round-robin reference model

module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic clk;
    logic rst;
    int   cmp_count;
    int   err_count;
    int   mptr;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(50)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: first requester at or after the pointer, wrapping mod N.
    function automatic int model_winner(input logic [N-1:0] r, input int p);
        for (int d = 0; d < N; d++) begin
            if (r[(p + d) % N]) return (p + d) % N;
        end
        return -1;
    endfunction

    task automatic do_frame(input logic [N-1:0] r, input logic [31:0] d, input int delay,
                            input bit stale, input bit drop_after);
        int         w;
        logic [3:0] eg;
        logic [7:0] eb;
        w  = model_winner(r, mptr);
        eg = 4'b0001 << w;
        eb = d[w*8 +: 8];
        bus.req      = r;
        bus.req_data = d;
        if (stale) bus.uart_donetx = 1'b1;
        @(negedge clk);
        cmp_count++;
        if ({bus.gnt, bus.owner, bus.uart_dintx, bus.uart_newd, bus.busy} !== {eg, 2'(w), eb, 1'b1, 1'b1}) begin
            err_count++;
            $display("FAIL grant: got gnt=%b owner=%0d dintx=%h newd=%b busy=%b want gnt=%b owner=%0d dintx=%h newd=1 busy=1",
                     bus.gnt, bus.owner, bus.uart_dintx, bus.uart_newd, bus.busy, eg, w, eb);
        end
        mptr = (w + 1) % N;
        if (drop_after) bus.req = '0;
        if (stale) begin
            repeat (3) begin
                @(negedge clk);
                cmp_count++;
                if ({bus.tx_done, bus.uart_newd} !== {4'b0000, 1'b1}) begin
                    err_count++;
                    $display("FAIL stale_donetx: got tx_done=%b newd=%b want tx_done=0000 newd=1",
                             bus.tx_done, bus.uart_newd);
                end
            end
            bus.uart_donetx = 1'b0;
        end
        repeat (delay) begin
            @(negedge clk);
            cmp_count++;
            if ({bus.gnt, bus.uart_newd, bus.tx_done, bus.busy, bus.uart_dintx} !== {4'b0000, 1'b1, 4'b0000, 1'b1, eb}) begin
                err_count++;
                $display("FAIL send_hold: got gnt=%b newd=%b tx_done=%b busy=%b dintx=%h want 0000/1/0000/1/%h",
                         bus.gnt, bus.uart_newd, bus.tx_done, bus.busy, bus.uart_dintx, eb);
            end
        end
        bus.uart_donetx = 1'b1;
        @(negedge clk);
        cmp_count++;
        if ({bus.tx_done, bus.uart_newd, bus.busy, bus.tx_err} !== {eg, 1'b0, 1'b1, 1'b0}) begin
            err_count++;
            $display("FAIL tx_done: got tx_done=%b newd=%b busy=%b tx_err=%b want tx_done=%b newd=0 busy=1 tx_err=0",
                     bus.tx_done, bus.uart_newd, bus.busy, bus.tx_err, eg);
        end
        bus.uart_donetx = 1'b0;
        @(negedge clk);
        cmp_count++;
        if ({bus.tx_done, bus.busy, bus.gnt} !== {4'b0000, 1'b0, 4'b0000}) begin
            err_count++;
            $display("FAIL done_state: got tx_done=%b busy=%b gnt=%b want 0000/0/0000",
                     bus.tx_done, bus.busy, bus.gnt);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.req = '0;
        bus.req_data = '0;
        bus.uart_donetx = 1'b0;
        mptr = 0;
        repeat (2) @(negedge clk);
        cmp_count++;
        if ({bus.gnt, bus.tx_done, bus.tx_err, bus.busy, bus.owner, bus.uart_dintx, bus.uart_newd} !== 21'd0) begin
            err_count++;
            $display("FAIL reset_state: got gnt=%b tx_done=%b tx_err=%b busy=%b owner=%0d dintx=%h newd=%b want all 0",
                     bus.gnt, bus.tx_done, bus.tx_err, bus.busy, bus.owner, bus.uart_dintx, bus.uart_newd);
        end
        rst = 1'b1;
        @(negedge clk);
        cmp_count++;
        if ({bus.gnt, bus.busy} !== 5'd0) begin
            err_count++;
            $display("FAIL idle_no_req: got gnt=%b busy=%b want 0000/0", bus.gnt, bus.busy);
        end
    endtask

    task automatic test_round_robin;
        for (int k = 0; k < 5; k++) begin
            do_frame(4'b1111, 32'h4332_2110, 2 + k, 1'b0, 1'b0);
        end
    endtask

    task automatic test_single;
`ifdef UART_ARB_TIMEOUT_EN
        do_frame(4'b0100, 32'h00A5_0000, 30, 1'b0, 1'b1);
`else
        do_frame(4'b0100, 32'h00A5_0000, 100, 1'b0, 1'b1);
`endif
    endtask

    task automatic test_wrap;
        do_frame(4'b1001, 32'h7700_0066, 3, 1'b0, 1'b0);
        do_frame(4'b1001, 32'h7700_0066, 3, 1'b0, 1'b1);
    endtask

    task automatic test_stale_donetx;
        do_frame(4'b0010, 32'h0000_5A00, 4, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_send;
        bus.req = 4'b0010;
        bus.req_data = 32'h0000_C300;
        @(negedge clk);
        bus.req = '0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        cmp_count++;
        if ({bus.gnt, bus.tx_done, bus.tx_err, bus.busy, bus.owner, bus.uart_dintx, bus.uart_newd} !== 21'd0) begin
            err_count++;
            $display("FAIL async_reset: got gnt=%b tx_done=%b tx_err=%b busy=%b owner=%0d dintx=%h newd=%b want all 0",
                     bus.gnt, bus.tx_done, bus.tx_err, bus.busy, bus.owner, bus.uart_dintx, bus.uart_newd);
        end
        bus.uart_donetx = 1'b1;
        repeat (2) begin
            @(negedge clk);
            cmp_count++;
            if (bus.tx_done !== 4'b0000) begin
                err_count++;
                $display("FAIL reset_no_done: got tx_done=%b want 0000", bus.tx_done);
            end
        end
        bus.uart_donetx = 1'b0;
        rst = 1'b1;
        mptr = 0;
        @(negedge clk);
        do_frame(4'b0001, 32'h0000_0042, 2, 1'b0, 1'b1);
    endtask

    task automatic test_random;
        logic [N-1:0] r;
        for (int k = 0; k < 20; k++) begin
            r = 4'($urandom_range(1, 15));
            do_frame(r, $urandom, $urandom_range(1, 20), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_watchdog;
        bus.req = 4'b0100;
        bus.req_data = 32'h00E7_0000;
        @(negedge clk);
        mptr = 3;
        bus.req = '0;
        for (int c = 1; c < 50; c++) begin
            @(negedge clk);
            cmp_count++;
            if ({bus.tx_err, bus.uart_newd} !== 2'b01) begin
                err_count++;
                $display("FAIL wd_wait cycle %0d: got tx_err=%b newd=%b want 0/1", c, bus.tx_err, bus.uart_newd);
            end
        end
        @(negedge clk);
`ifdef UART_ARB_TIMEOUT_EN
        cmp_count++;
        if ({bus.tx_err, bus.uart_newd, bus.tx_done, bus.busy} !== {1'b1, 1'b0, 4'b0000, 1'b1}) begin
            err_count++;
            $display("FAIL wd_abort: got tx_err=%b newd=%b tx_done=%b busy=%b want 1/0/0000/1",
                     bus.tx_err, bus.uart_newd, bus.tx_done, bus.busy);
        end
        @(negedge clk);
        cmp_count++;
        if ({bus.tx_err, bus.busy, bus.tx_done} !== 6'd0) begin
            err_count++;
            $display("FAIL wd_done: got tx_err=%b busy=%b tx_done=%b want 0/0/0000",
                     bus.tx_err, bus.busy, bus.tx_done);
        end
`else
        repeat (20) begin
            cmp_count++;
            if ({bus.tx_err, bus.uart_newd, bus.busy} !== 3'b011) begin
                err_count++;
                $display("FAIL no_watchdog: got tx_err=%b newd=%b busy=%b want 0/1/1",
                         bus.tx_err, bus.uart_newd, bus.busy);
            end
            @(negedge clk);
        end
        bus.uart_donetx = 1'b1;
        @(negedge clk);
        bus.uart_donetx = 1'b0;
        cmp_count++;
        if (bus.tx_done !== 4'b0100) begin
            err_count++;
            $display("FAIL late_done: got tx_done=%b want 0100", bus.tx_done);
        end
        @(negedge clk);
`endif
        do_frame(4'b1100, 32'h9988_0000, 2, 1'b0, 1'b1);
    endtask

    initial begin
        cmp_count = 0;
        err_count = 0;
        test_reset();
        test_round_robin();
        test_single();
        test_wrap();
        test_stale_donetx();
        test_reset_mid_send();
        test_random();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end
endmodule
